fpga_cfg_loader: RTL and testbench
==================================

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 Parameter: CFG_BITS, 256, length of the fabric configuration chain in bits; SHALL be a non-zero multiple of 8.
REQ-002 clk  input  1  single design clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  design enable; low freezes all state.
REQ-005 cfg_mode  input  1  high requests configuration; low returns to user mode.
REQ-006 cfg_valid  input  1  cfg_data holds a valid byte.
REQ-007 cfg_data  input  8  bitstream byte.
REQ-008 cfg_ready  output  1  loader accepts a byte this cycle.
REQ-009 cfg_shift_en  output  1  config chain advances one bit this cycle.
REQ-010 cfg_shift_bit  output  1  bit presented to the chain head.
REQ-011 cfg_done  output  1  sticky: full chain loaded (and checked, if enabled).
REQ-012 cfg_err  output  1  sticky: integrity check failed.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT, CHECK, DONE, ERR.
REQ-014 IDLE->LOAD when cfg_mode=1; entry clears bit counter, CRC accumulator, cfg_done, cfg_err.
REQ-015 Byte transfer SHALL occur only on an edge where cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be high only in LOAD and CHECK.
REQ-016 Byte accepted at edge N: cfg_shift_en high for exactly cycles N+1..N+8, cfg_shift_bit = byte bit k (LSB first) in cycle N+1+k.
REQ-017 After the 8th shift: LOAD if bits shifted < CFG_BITS, else CHECK (CRC enabled) or DONE; peak rate is one byte per 9 cycles.
REQ-018 cfg_shift_en SHALL be 0 and cfg_shift_bit 0 outside SHIFT.
REQ-019 Bit counter SHALL be $clog2(CFG_BITS+1) wide and never wrap; bytes offered after the chain is full SHALL not be accepted (cfg_ready=0).
REQ-020 DONE sets cfg_done; ERR sets cfg_err; both states hold until cfg_mode=0, then IDLE; flags stay set in IDLE.
REQ-021 cfg_mode=0 in LOAD, SHIFT or CHECK aborts to IDLE next edge: shifting stops immediately, cfg_done and cfg_err stay 0.
REQ-022 ena=0 SHALL hold state and counters and force cfg_ready=0 and cfg_shift_en=0; resumption continues from the held bit position.
REQ-023 cfg_mode rising while in IDLE with cfg_done=1 SHALL start a fresh load (REQ-014).

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, counters and CRC to 0, and all outputs to 0, regardless of clk.
REQ-025 Reset release mid-bitstream SHALL require a new cfg_mode rising edge; no partial resume.

Configuration
REQ-026 Macro FPGA_CFG_CRC_EN defined: CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over all payload bytes; CHECK accepts one trailing byte without shifting; match->DONE, mismatch->ERR.
REQ-027 Macro undefined: CHECK unreachable, cfg_err tied 0, DONE entered directly after the last shift; no CRC logic synthesized.

Structure
REQ-028 Package fpga_cfg_pkg SHALL hold the FSM state enum, CRC polynomial constant 8'h07 and the default CFG_BITS.
REQ-029 One sub-module cfg_crc8 (byte-wide combinational CRC update, registered in the loader) SHALL exist and be instantiated only under FPGA_CFG_CRC_EN.

Verification
REQ-030 CFG_BITS=16, bytes 0xA5,0x3C, no CRC -> shift bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; cfg_done=1 after 18 cycles from first transfer.
REQ-031 CRC on, CFG_BITS=72, payload ASCII "123456789", trailing 0xF4 -> cfg_done=1, cfg_err=0; trailing 0xF5 -> cfg_err=1, cfg_done=0.
REQ-032 cfg_valid held high continuously -> cfg_ready pulses once per 9 cycles, no byte lost or duplicated.
REQ-033 cfg_mode dropped during 3rd shift cycle of byte 2 -> cfg_shift_en low next cycle, IDLE, flags 0; reload completes normally.
REQ-034 rst_n asserted mid-SHIFT between clock edges -> outputs 0 immediately; ena=0 for 5 cycles mid-SHIFT -> bit sequence unchanged, only delayed 5 cycles.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
// Holds the loader FSM states, the CRC-8 polynomial and the default chain length.
package fpga_cfg_pkg;

    localparam int unsigned CFG_BITS_DEFAULT = 256;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK,
        DONE,
        ERR
    } cfg_state_e;

endpackage

// File: rtl/cfg_crc8.sv
// Byte-wide combinational CRC-8 update: MSB-first, polynomial CRC8_POLY, no reflection.
// The caller holds the running CRC in a register.
module cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] c;

    always_comb begin
        c = crc_i ^ data_i;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-fed loader that shifts a bitstream LSB-first into a CFG_BITS-long config chain.
// Define FPGA_CFG_CRC_EN to add a trailing CRC-8 byte check (CHECK/ERR states, cfg_crc8).
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cfg_mode,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_data,
    output logic       cfg_ready,
    output logic       cfg_shift_en,
    output logic       cfg_shift_bit,
    output logic       cfg_done,
    output logic       cfg_err
);

    localparam int unsigned   CW       = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CFG_BITS - 1);

    cfg_state_e    state_q, state_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          mode_q, mode_d;
    logic          done_q, done_d;
    logic          start;

`ifdef FPGA_CFG_CRC_EN
    logic [7:0] crc_q, crc_d, crc_upd;
    logic       err_q, err_d;

    cfg_crc8 u_crc8 (
        .crc_i  (crc_q),
        .data_i (cfg_data),
        .crc_o  (crc_upd)
    );
`endif

    assign start = cfg_mode & ~mode_q;

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        shreg_d       = shreg_q;
        mode_d        = mode_q;
        done_d        = done_q;
`ifdef FPGA_CFG_CRC_EN
        crc_d         = crc_q;
        err_d         = err_q;
`endif
        cfg_ready     = 1'b0;
        cfg_shift_en  = 1'b0;
        cfg_shift_bit = 1'b0;

        if (ena) begin
            mode_d = cfg_mode;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = LOAD;
                        bitcnt_d = '0;
                        done_d   = 1'b0;
`ifdef FPGA_CFG_CRC_EN
                        crc_d    = '0;
                        err_d    = 1'b0;
`endif
                    end
                end
                LOAD: begin
                    cfg_ready = cfg_mode;
                    if (!cfg_mode) begin
                        state_d = IDLE;
                    end else if (cfg_valid) begin
                        shreg_d = cfg_data;
`ifdef FPGA_CFG_CRC_EN
                        crc_d   = crc_upd;
`endif
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    // Gated by cfg_mode so an abort stops the chain in the same cycle.
                    cfg_shift_en  = cfg_mode;
                    cfg_shift_bit = cfg_mode & shreg_q[0];
                    if (!cfg_mode) begin
                        state_d = IDLE;
                    end else begin
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q[2:0] == 3'd7) begin
                            if (bitcnt_q != LAST_BIT) begin
                                state_d = LOAD;
                            end else begin
`ifdef FPGA_CFG_CRC_EN
                                state_d = CHECK;
`else
                                state_d = DONE;
                                done_d  = 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef FPGA_CFG_CRC_EN
                CHECK: begin
                    cfg_ready = cfg_mode;
                    if (!cfg_mode) begin
                        state_d = IDLE;
                    end else if (cfg_valid) begin
                        if (cfg_data == crc_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (!cfg_mode) state_d = IDLE;
                end
`endif
                DONE: begin
                    if (!cfg_mode) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // mode_q resets high so a cfg_mode level held across reset is not taken as a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            mode_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
            crc_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
`ifdef FPGA_CFG_CRC_EN
            crc_q    <= crc_d;
            err_q    <= err_d;
`endif
        end
    end

    assign cfg_done = done_q;
`ifdef FPGA_CFG_CRC_EN
    assign cfg_err  = err_q;
`else
    assign cfg_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: vector table, directed corner cases, randomized loads.
// Chain length is 16 bits by default, 72 bits when FPGA_CFG_CRC_EN is defined.
`timescale 1ns/1ps
module tb_fpga_cfg_loader;

`ifdef FPGA_CFG_CRC_EN
    localparam int CB      = 72;
    localparam int HAS_CRC = 1;
`else
    localparam int CB      = 16;
    localparam int HAS_CRC = 0;
`endif
    localparam int NOM_LAT = (CB / 8) * 9 + HAS_CRC;
    localparam int BUDGET  = (CB / 8) * 40 + 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cfg_mode = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, cfg_shift_en, cfg_shift_bit, cfg_done, cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] pay_q[$];
    logic [7:0] stim_q[$];
    logic       got_q[$];
    int         acc_q[$];

    typedef struct {
        logic       mode;
        logic       valid;
        logic       en;
        logic [7:0] data;
        logic       ready;
        logic       sen;
        logic       sbit;
        logic       done;
    } vec_t;
    vec_t tv[12];

    fpga_cfg_loader #(.CFG_BITS(CB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .cfg_mode      (cfg_mode),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .cfg_shift_en  (cfg_shift_en),
        .cfg_shift_bit (cfg_shift_bit),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-8, processed one message bit at a time.
    function automatic logic [7:0] crc_ref();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (pay_q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ pay_q[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic fill_random(input bit corrupt);
        logic [7:0] k;
        pay_q.delete();
        for (int i = 0; i < CB / 8; i++) pay_q.push_back(8'($urandom));
        stim_q = pay_q;
`ifdef FPGA_CFG_CRC_EN
        k = corrupt ? 8'($urandom_range(255, 1)) : 8'h00;
        stim_q.push_back(crc_ref() ^ k);
`else
        k = {7'd0, corrupt};
`endif
    endtask

    task automatic do_load(input int vpct, input int epct, input int gap_at, output int lat);
        int idx, cyc, first, gap, nsh;
        bit fin;
        idx = 0; cyc = 0; first = -1; gap = 0; nsh = 0; fin = 0; lat = -1;
        got_q.delete();
        acc_q.delete();
        while (!fin && cyc < BUDGET) begin
            @(negedge clk);
            if (cyc > 0 && (cfg_done || cfg_err)) begin
                fin = 1;
                lat = cyc - first;
            end else begin
                cfg_mode = 1'b1;
                if (gap > 0) begin
                    ena = 1'b0;
                    gap--;
                end else begin
                    ena = (cyc == 0) || ($urandom_range(99) < epct);
                end
                cfg_valid = ($urandom_range(99) < vpct);
                cfg_data  = (idx < stim_q.size()) ? stim_q[idx] : 8'($urandom);
                #1;
                if (cfg_shift_en) begin
                    got_q.push_back(cfg_shift_bit);
                    nsh++;
                    if (nsh == gap_at) gap = 5;
                end
                if (cfg_valid && cfg_ready) begin
                    if (first < 0) first = cyc;
                    acc_q.push_back(cyc);
                    idx++;
                end
                cyc++;
            end
        end
        if (!fin) chk("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_check(input string tag, input int vpct, input int epct,
                             input int gap_at, input int exp_lat);
        int lat, mism, bad, busy;
        logic [7:0] b;
        logic exp_done, exp_err;
        exp_done = 1'b1;
        exp_err  = 1'b0;
`ifdef FPGA_CFG_CRC_EN
        exp_done = (stim_q[stim_q.size() - 1] == crc_ref());
        exp_err  = !exp_done;
`endif
        do_load(vpct, epct, gap_at, lat);
        chk({tag, "_nbits"}, got_q.size(), CB);
        mism = 0;
        for (int i = 0; i < CB; i++) begin
            b = pay_q[i / 8];
            if (i >= got_q.size() || got_q[i] !== b[i % 8]) mism++;
        end
        chk({tag, "_bits"}, mism, 0);
        chk({tag, "_done"}, cfg_done, exp_done);
        chk({tag, "_err"}, cfg_err, exp_err);
        if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
        if (vpct == 100 && epct == 100) begin
            bad = 0;
            for (int i = 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i - 1] != 9) bad++;
            chk({tag, "_spacing"}, bad, 0);
            chk({tag, "_naccept"}, acc_q.size(), stim_q.size());
        end
        busy = 0;
        repeat (4) begin
            @(negedge clk);
            cfg_mode = 1'b1; ena = 1'b1; cfg_valid = 1'b1; cfg_data = 8'($urandom);
            #1;
            busy += int'(cfg_ready) + int'(cfg_shift_en);
        end
        chk({tag, "_full_idle"}, busy, 0);
        @(negedge clk);
        cfg_mode = 1'b0; cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_sticky_done"}, cfg_done, exp_done);
        chk({tag, "_sticky_err"}, cfg_err, exp_err);
        chk({tag, "_idle_ready"}, cfg_ready, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int nsh, busy;
        tv[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with inputs active: every output must be low.
        rst_n = 1'b0; ena = 1'b1; cfg_mode = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_shift_en", cfg_shift_en, 1'b0);
        chk("rst_shift_bit", cfg_shift_bit, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; cfg_mode = 1'b0; cfg_valid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cfg_mode = tv[i].mode; cfg_valid = tv[i].valid; ena = tv[i].en; cfg_data = tv[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_ready", i), cfg_ready, tv[i].ready);
            chk($sformatf("tv%0d_shift_en", i), cfg_shift_en, tv[i].sen);
            chk($sformatf("tv%0d_shift_bit", i), cfg_shift_bit, tv[i].sbit);
            chk($sformatf("tv%0d_done", i), cfg_done, tv[i].done);
        end
        @(negedge clk);
        cfg_mode = 1'b0;

        // Known bitstreams, valid held high, no enable gaps.
`ifdef FPGA_CFG_CRC_EN
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        stim_q = pay_q;
        stim_q.push_back(8'hF4);
        run_check("crc_good", 100, 100, -1, NOM_LAT);
        stim_q[stim_q.size() - 1] = 8'hF5;
        run_check("crc_bad", 100, 100, -1, -1);
`else
        pay_q = '{8'hA5, 8'h3C};
        stim_q = pay_q;
        run_check("a5_3c", 100, 100, -1, NOM_LAT);
`endif

        // Enable low for 5 cycles in the middle of the second byte.
        fill_random(0);
        run_check("ena_gap", 100, 100, 11, NOM_LAT + 5);

        // Abort during the 3rd shift cycle of byte 2.
        fill_random(0);
        nsh = 0;
        for (int c = 0; c < 100 && nsh < 10; c++) begin
            @(negedge clk);
            cfg_mode = 1'b1; ena = 1'b1; cfg_valid = 1'b1; cfg_data = 8'($urandom);
            #1;
            if (cfg_shift_en) nsh++;
        end
        chk("abort_reach", nsh, 10);
        @(negedge clk);
        cfg_mode = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_shift_en", cfg_shift_en, 1'b0);
        chk("abort_ready", cfg_ready, 1'b0);
        chk("abort_done", cfg_done, 1'b0);
        chk("abort_err", cfg_err, 1'b0);
        @(negedge clk);
        run_check("reload", 100, 100, -1, NOM_LAT);

        // Asynchronous reset between edges mid-shift, then mode held high across release.
        fill_random(0);
        nsh = 0;
        for (int c = 0; c < 100 && nsh < 3; c++) begin
            @(negedge clk);
            cfg_mode = 1'b1; ena = 1'b1; cfg_valid = 1'b1; cfg_data = stim_q[0];
            #1;
            if (cfg_shift_en) nsh++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_shift_en", cfg_shift_en, 1'b0);
        chk("arst_shift_bit", cfg_shift_bit, 1'b0);
        chk("arst_ready", cfg_ready, 1'b0);
        chk("arst_done", cfg_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            busy += int'(cfg_ready) + int'(cfg_shift_en);
        end
        chk("arst_no_resume", busy, 0);
        @(negedge clk);
        cfg_mode = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        run_check("post_rst", 100, 100, -1, NOM_LAT);

        // Randomized traffic with valid and enable gaps.
        for (int t = 0; t < 6; t++) begin
            fill_random(t % 2 == 1);
            run_check($sformatf("rand%0d", t), 60, 80, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
